// File: rtl/sram_ctrl256kx16.sv
`default_nettype none
// ============================================================================
//  Module   : sram_ctrl256kx16
//  Purpose  : Initiator for an external asynchronous 256K x 16 SRAM. Turns a
//             single-cycle 32-bit big-endian word request into one or two
//             16-bit SRAM accesses with programmable strobe width.
//  Ports    : clock, reset_n          - clock / async active-low reset
//             req, we, addr, be, wdata - request side (sampled in IDLE only)
//             rdata, done, busy        - completion side
//             sram_addr, sram_io       - halfword address / tri-state data
//             sram_ce_n/we_n/oe_n/ub_n/lb_n - active-low SRAM controls
//  Revision : 1.0 - initial release
// ============================================================================
module sram_ctrl256kx16 #(
  parameter int WAIT_STATES = 1     // strobe cycles per halfword, 1..15
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req,
  input  logic        we,
  input  logic [18:0] addr,
  input  logic [3:0]  be,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        done,
  output logic        busy,
  output logic [17:0] sram_addr,
  inout  wire  [15:0] sram_io,
  output logic        sram_ce_n,
  output logic        sram_we_n,
  output logic        sram_oe_n,
  output logic        sram_ub_n,
  output logic        sram_lb_n
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_PULSE = 3'd2,
    S_HOLD  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [3:0] c_wait_load = 4'(WAIT_STATES - 1);

  state_t      r_state, w_state_nxt;
  logic        r_hw, w_hw_nxt;          // 0 = H0 (data[31:16]), 1 = H1
  logic [3:0]  r_cnt, w_cnt_nxt;

  logic        r_we;
  logic [16:0] r_word;                   // addr[18:2]
  logic [3:0]  r_be;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_done, r_busy;
  logic [17:0] r_sram_addr;
  logic        r_ce_n, r_we_n, r_oe_n, r_ub_n, r_lb_n;
  logic        r_drive;
  logic [15:0] r_dout;

  // Request fields as seen by the output decode: straight from the inputs on
  // the acceptance edge, from the captured copies afterwards.
  logic        w_accept, w_we_eff;
  logic [16:0] w_word_eff;
  logic [3:0]  w_be_eff;
  logic [31:0] w_wdata_eff;
  logic        w_cap_hi, w_cap_lo, w_active;
  logic        w_ce_n, w_we_n, w_oe_n, w_ub_n, w_lb_n, w_drive;
  logic [17:0] w_sram_addr;
  logic [15:0] w_dout;

  // Word access: the byte offset bits carry no information.
  logic        w_unused;
  assign w_unused = ^addr[1:0];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_hw    <= 1'b0;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_hw    <= w_hw_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_hw_nxt    = r_hw;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_cap_hi    = 1'b0;
    w_cap_lo    = 1'b0;
    w_we_eff    = r_we;
    w_word_eff  = r_word;
    w_be_eff    = r_be;
    w_wdata_eff = r_wdata;

    case (r_state)
      S_IDLE: begin
        if (req) begin
          w_accept    = 1'b1;
          w_we_eff    = we;
          w_word_eff  = addr[18:2];
          w_be_eff    = be;
          w_wdata_eff = wdata;
          // Reads always fetch both halves; writes skip disabled halves.
          if (!we || (be[3] | be[2])) begin
            w_state_nxt = S_ADDR;
            w_hw_nxt    = 1'b0;
          end else if (be[1] | be[0]) begin
            w_state_nxt = S_ADDR;
            w_hw_nxt    = 1'b1;
          end else begin
            w_state_nxt = S_DONE;
          end
        end
      end
      S_ADDR: begin
        w_state_nxt = S_PULSE;
        w_cnt_nxt   = c_wait_load;
      end
      S_PULSE: begin
        if (r_cnt == 4'd0) begin
          if (r_we) begin
            w_state_nxt = S_HOLD;
          end else if (!r_hw) begin
            w_state_nxt = S_ADDR;
            w_hw_nxt    = 1'b1;
            w_cap_hi    = 1'b1;
          end else begin
            w_state_nxt = S_DONE;
            w_cap_lo    = 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      S_HOLD: begin
        if (!r_hw && (r_be[1] | r_be[0])) begin
          w_state_nxt = S_ADDR;
          w_hw_nxt    = 1'b1;
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase

    // Pin levels are decoded from the state being entered and registered,
    // so every strobe changes only on a clock edge.
    w_active = (w_state_nxt == S_ADDR) || (w_state_nxt == S_PULSE) ||
               (w_state_nxt == S_HOLD);
    w_ce_n   = !w_active;
    w_oe_n   = !(w_active && !w_we_eff);
    w_we_n   = !((w_state_nxt == S_PULSE) && w_we_eff);
    w_drive  = w_active && w_we_eff;
    w_ub_n   = 1'b1;
    w_lb_n   = 1'b1;
    if (w_active) begin
      if (!w_we_eff) begin
        w_ub_n = 1'b0;
        w_lb_n = 1'b0;
      end else if (w_hw_nxt) begin
        w_ub_n = !w_be_eff[1];
        w_lb_n = !w_be_eff[0];
      end else begin
        w_ub_n = !w_be_eff[3];
        w_lb_n = !w_be_eff[2];
      end
    end
    w_sram_addr = w_active ? {w_word_eff, w_hw_nxt} : r_sram_addr;
    w_dout      = w_hw_nxt ? w_wdata_eff[15:0] : w_wdata_eff[31:16];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_we        <= 1'b0;
      r_word      <= 17'd0;
      r_be        <= 4'd0;
      r_wdata     <= 32'd0;
      r_rdata     <= 32'd0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
      r_sram_addr <= 18'd0;
      r_ce_n      <= 1'b1;
      r_we_n      <= 1'b1;
      r_oe_n      <= 1'b1;
      r_ub_n      <= 1'b1;
      r_lb_n      <= 1'b1;
      r_drive     <= 1'b0;
      r_dout      <= 16'd0;
    end else begin
      if (w_accept) begin
        r_we    <= we;
        r_word  <= addr[18:2];
        r_be    <= be;
        r_wdata <= wdata;
      end
      if (w_cap_hi) r_rdata[31:16] <= sram_io;
      if (w_cap_lo) r_rdata[15:0]  <= sram_io;
      r_done      <= (w_state_nxt == S_DONE);
      r_busy      <= (w_state_nxt != S_IDLE);
      r_sram_addr <= w_sram_addr;
      r_ce_n      <= w_ce_n;
      r_we_n      <= w_we_n;
      r_oe_n      <= w_oe_n;
      r_ub_n      <= w_ub_n;
      r_lb_n      <= w_lb_n;
      r_drive     <= w_drive;
      r_dout      <= w_dout;
    end
  end

  assign sram_io   = r_drive ? r_dout : 16'hzzzz;
  assign rdata     = r_rdata;
  assign done      = r_done;
  assign busy      = r_busy;
  assign sram_addr = r_sram_addr;
  assign sram_ce_n = r_ce_n;
  assign sram_we_n = r_we_n;
  assign sram_oe_n = r_oe_n;
  assign sram_ub_n = r_ub_n;
  assign sram_lb_n = r_lb_n;

endmodule
`default_nettype wire

// File: tb/tb_sram_ctrl256kx16.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sram_ctrl256kx16
//  Purpose  : Self-checking bench for sram_ctrl256kx16. One instance with
//             WAIT_STATES=1 on a behavioural SRAM, one with WAIT_STATES=3 on
//             a read-only SRAM whose halfword contents equal their address.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sram_ctrl256kx16;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  always #10 clock = ~clock;

  // ---------------- instance 1 (WAIT_STATES = 1) ----------------
  logic        req = 1'b0, we = 1'b0;
  logic [18:0] addr = '0;
  logic [3:0]  be = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata1;
  logic        done1, busy1, ce1, we1n, oe1, ub1, lb1;
  logic [17:0] sa1;
  wire  [15:0] io1;

  sram_ctrl256kx16 #(.WAIT_STATES(1)) dut1 (
    .clock(clock), .reset_n(reset_n), .req(req), .we(we), .addr(addr),
    .be(be), .wdata(wdata), .rdata(rdata1), .done(done1), .busy(busy1),
    .sram_addr(sa1), .sram_io(io1), .sram_ce_n(ce1), .sram_we_n(we1n),
    .sram_oe_n(oe1), .sram_ub_n(ub1), .sram_lb_n(lb1));

  // Asynchronous SRAM: drives on ce&oe&!we, latches bytes at the we_n rise.
  logic [15:0] mem1 [0:262143];
  bit          model_en = 1'b0;
  assign io1 = (!ce1 && !oe1 && we1n) ? mem1[sa1] : 16'hzzzz;
  always @(posedge we1n) begin
    if (model_en && !ce1) begin
      if (!ub1) mem1[sa1][15:8] = io1[15:8];
      if (!lb1) mem1[sa1][7:0]  = io1[7:0];
    end
  end

  // ---------------- instance 3 (WAIT_STATES = 3) ----------------
  logic        req3 = 1'b0, we3 = 1'b0;
  logic [18:0] addr3 = '0;
  logic [3:0]  be3 = '0;
  logic [31:0] wdata3 = '0;
  logic [31:0] rdata3;
  logic        done3, busy3, ce3, we3n, oe3, ub3, lb3;
  logic [17:0] sa3;
  wire  [15:0] io3;

  sram_ctrl256kx16 #(.WAIT_STATES(3)) dut3 (
    .clock(clock), .reset_n(reset_n), .req(req3), .we(we3), .addr(addr3),
    .be(be3), .wdata(wdata3), .rdata(rdata3), .done(done3), .busy(busy3),
    .sram_addr(sa3), .sram_io(io3), .sram_ce_n(ce3), .sram_we_n(we3n),
    .sram_oe_n(oe3), .sram_ub_n(ub3), .sram_lb_n(lb3));

  assign io3 = (!ce3 && !oe3 && we3n) ? sa3[15:0] : 16'hzzzz;

  // ---------------- reference model and bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] ref_hw [int];

  function automatic logic [15:0] ref_get(int h);
    return ref_hw.exists(h) ? ref_hw[h] : 16'(h);
  endfunction

  function automatic logic [31:0] ref_read(logic [18:0] a);
    int h;
    h = int'(a >> 2) * 2;
    return {ref_get(h), ref_get(h + 1)};
  endfunction

  // Byte k of the word (k=0 is data[31:24]) lives in halfword word*2+k/2,
  // upper lane for even k.
  task automatic ref_write(logic [18:0] a, logic [3:0] b, logic [31:0] d);
    for (int k = 0; k < 4; k++) begin
      if (b[3-k]) begin
        int h;
        logic [15:0] v;
        h = int'(a >> 2) * 2 + k / 2;
        v = ref_get(h);
        if (k % 2 == 0) v[15:8] = d[31-8*k -: 8];
        else            v[7:0]  = d[31-8*k -: 8];
        ref_hw[h] = v;
      end
    end
  endtask

  function automatic int exp_lat(bit w, logic [3:0] b, int ws);
    int n;
    n = int'(b[3] | b[2]) + int'(b[1] | b[0]);
    if (!w)     return 2 * (ws + 1) + 1;
    if (n == 0) return 1;
    return n * (ws + 2) + 1;
  endfunction

  // Observations from the last access on instance 1.
  int          o_lat, o_we_low, o_oe_low, o_ce_low, o_done, o_bad, o_post;
  logic [31:0] o_rdata;

  task automatic run1(input bit w, input logic [18:0] a, input logic [3:0] b,
                      input logic [31:0] d, input bit hold);
    o_lat = -1; o_we_low = 0; o_oe_low = 0; o_ce_low = 0;
    o_done = 0; o_bad = 0; o_post = 0; o_rdata = '0;
    @(negedge clock);
    req = 1'b1; we = w; addr = a; be = b; wdata = d;
    @(posedge clock);
    for (int c = 1; c <= 100; c++) begin
      @(negedge clock);
      if (!hold) req = 1'b0;
      if (!ce1) o_ce_low++;
      if (!we1n) begin
        o_we_low++;
        if (ub1 !== !(sa1[0] ? b[1] : b[3]) || lb1 !== !(sa1[0] ? b[0] : b[2]) ||
            sa1[17:1] !== a[18:2] || ce1 !== 1'b0 || oe1 !== 1'b1) o_bad++;
      end
      if (!oe1) begin
        o_oe_low++;
        if (we1n !== 1'b1 || ub1 !== 1'b0 || lb1 !== 1'b0 ||
            sa1[17:1] !== a[18:2]) o_bad++;
      end
      if (done1) begin
        o_done++;
        o_lat   = c;
        o_rdata = rdata1;
        if (ce1 !== 1'b1 || oe1 !== 1'b1 || we1n !== 1'b1 || ub1 !== 1'b1 ||
            lb1 !== 1'b1 || busy1 !== 1'b1) o_bad++;
        break;
      end
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      req = 1'b0;
      if (!ce1 || done1 || busy1) o_post++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    #1 reset_n = 1'b0;
    #1;
    n_checks++;
    if ({ce1, we1n, oe1, ub1, lb1} !== 5'b11111) begin
      n_fail++; $display("FAIL reset_strobes1: got %b, expected 11111", {ce1, we1n, oe1, ub1, lb1});
    end
    n_checks++;
    if ({busy1, done1} !== 2'b00) begin
      n_fail++; $display("FAIL reset_busy_done1: got %b, expected 00", {busy1, done1});
    end
    n_checks++;
    if (rdata1 !== 32'd0) begin
      n_fail++; $display("FAIL reset_rdata1: got %h, expected 0", rdata1);
    end
    n_checks++;
    if (sa1 !== 18'd0) begin
      n_fail++; $display("FAIL reset_addr1: got %h, expected 0", sa1);
    end
    n_checks++;
    if ({ce3, we3n, oe3, ub3, lb3, busy3, done3} !== 7'b1111100 || rdata3 !== 32'd0) begin
      n_fail++; $display("FAIL reset_dut3: got %b/%h, expected 1111100/0",
                         {ce3, we3n, oe3, ub3, lb3, busy3, done3}, rdata3);
    end
    repeat (3) @(negedge clock);
    reset_n  = 1'b1;
    model_en = 1'b1;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_full_write;
    run1(1'b1, 19'h00100, 4'hF, 32'h12345678, 1'b0);
    ref_write(19'h00100, 4'hF, 32'h12345678);
    n_checks++;
    if (o_lat !== 7) begin n_fail++; $display("FAIL full_write_latency: got %0d, expected 7", o_lat); end
    n_checks++;
    if (o_we_low !== 2) begin n_fail++; $display("FAIL full_write_we_low: got %0d, expected 2", o_we_low); end
    n_checks++;
    if (o_bad !== 0 || o_oe_low !== 0) begin
      n_fail++; $display("FAIL full_write_strobes: bad=%0d oe_low=%0d, expected 0/0", o_bad, o_oe_low);
    end
    n_checks++;
    if (mem1[18'h00080] !== 16'h1234 || mem1[18'h00081] !== 16'h5678) begin
      n_fail++; $display("FAIL full_write_mem: got %h %h, expected 1234 5678", mem1[18'h00080], mem1[18'h00081]);
    end
  endtask

  task automatic test_read;
    run1(1'b0, 19'h00100, 4'h0, 32'h0, 1'b0);
    n_checks++;
    if (o_rdata !== 32'h12345678) begin n_fail++; $display("FAIL read_data: got %h, expected 12345678", o_rdata); end
    n_checks++;
    if (o_lat !== 5) begin n_fail++; $display("FAIL read_latency: got %0d, expected 5", o_lat); end
    n_checks++;
    if (o_oe_low !== 4 || o_we_low !== 0 || o_bad !== 0) begin
      n_fail++; $display("FAIL read_strobes: oe_low=%0d we_low=%0d bad=%0d, expected 4/0/0", o_oe_low, o_we_low, o_bad);
    end
  endtask

  task automatic test_partial_write;
    run1(1'b1, 19'h00100, 4'b0010, 32'h0000AB00, 1'b0);
    ref_write(19'h00100, 4'b0010, 32'h0000AB00);
    n_checks++;
    if (o_lat !== 4) begin n_fail++; $display("FAIL partial_latency: got %0d, expected 4", o_lat); end
    n_checks++;
    if (o_ce_low !== 3 || o_we_low !== 1 || o_bad !== 0) begin
      n_fail++; $display("FAIL partial_strobes: ce_low=%0d we_low=%0d bad=%0d, expected 3/1/0", o_ce_low, o_we_low, o_bad);
    end
    n_checks++;
    if (mem1[18'h00081] !== 16'hAB78 || mem1[18'h00080] !== 16'h1234) begin
      n_fail++; $display("FAIL partial_mem: got %h %h, expected 1234 AB78", mem1[18'h00080], mem1[18'h00081]);
    end
    n_checks++;
    if (rdata1 !== 32'h12345678) begin n_fail++; $display("FAIL partial_rdata_held: got %h, expected 12345678", rdata1); end
  endtask

  task automatic test_zero_be;
    run1(1'b1, 19'h00300, 4'b0000, 32'hDEADBEEF, 1'b1);
    n_checks++;
    if (o_lat !== 1) begin n_fail++; $display("FAIL zero_be_latency: got %0d, expected 1", o_lat); end
    n_checks++;
    if (o_ce_low !== 0 || o_we_low !== 0 || o_post !== 0) begin
      n_fail++; $display("FAIL zero_be_activity: ce_low=%0d we_low=%0d post=%0d, expected 0/0/0", o_ce_low, o_we_low, o_post);
    end
  endtask

  task automatic test_hold_req;
    logic [31:0] d;
    d = $urandom;
    run1(1'b1, 19'h00200, 4'hF, d, 1'b1);
    ref_write(19'h00200, 4'hF, d);
    n_checks++;
    if (o_done !== 1 || o_post !== 0 || o_we_low !== 2 || o_lat !== 7) begin
      n_fail++; $display("FAIL hold_req: done=%0d post=%0d we_low=%0d lat=%0d, expected 1/0/2/7", o_done, o_post, o_we_low, o_lat);
    end
    n_checks++;
    if ({mem1[18'h00100], mem1[18'h00101]} !== ref_read(19'h00200)) begin
      n_fail++; $display("FAIL hold_req_mem: got %h, expected %h", {mem1[18'h00100], mem1[18'h00101]}, ref_read(19'h00200));
    end
  endtask

  task automatic test_random;
    logic [31:0] last_rd, d;
    logic [18:0] a;
    logic [3:0]  b;
    bit          w;
    int          n;
    last_rd = 32'h12345678;
    for (int t = 0; t < 40; t++) begin
      w = $urandom_range(0, 1);
      a = 19'h01000 + 19'($urandom_range(0, 15) * 4);
      b = 4'($urandom);
      d = $urandom;
      run1(w, a, b, d, 1'b0);
      n_checks++;
      if (o_lat !== exp_lat(w, b, 1) || o_bad !== 0) begin
        n_fail++; $display("FAIL random_timing[%0d]: lat=%0d bad=%0d, expected %0d/0", t, o_lat, o_bad, exp_lat(w, b, 1));
      end
      if (w) begin
        ref_write(a, b, d);
        n = int'(b[3] | b[2]) + int'(b[1] | b[0]);
        n_checks++;
        if (o_we_low !== n || rdata1 !== last_rd) begin
          n_fail++; $display("FAIL random_write[%0d]: we_low=%0d rdata=%h, expected %0d/%h", t, o_we_low, rdata1, n, last_rd);
        end
      end else begin
        n_checks++;
        if (o_rdata !== ref_read(a) || o_oe_low !== 4) begin
          n_fail++; $display("FAIL random_read[%0d]: data=%h oe_low=%0d, expected %h/4", t, o_rdata, o_oe_low, ref_read(a));
        end
        last_rd = ref_read(a);
      end
    end
  endtask

  task automatic run3(input logic [18:0] a, output int lat, output logic [31:0] rd);
    lat = -1; rd = '0;
    @(negedge clock);
    req3 = 1'b1; we3 = 1'b0; addr3 = a;
    @(posedge clock);
    for (int c = 1; c <= 100; c++) begin
      @(negedge clock);
      req3 = 1'b0;
      if (done3) begin lat = c; rd = rdata3; break; end
    end
    @(negedge clock);
  endtask

  task automatic test_wait_states;
    int          lat;
    logic [31:0] rd, e;
    logic [18:0] a;
    // Byte address 0x00004 maps to halfwords 0x0002 and 0x0003.
    run3(19'h00004, lat, rd);
    n_checks++;
    if (rd !== 32'h00020003) begin n_fail++; $display("FAIL ws3_data: got %h, expected 00020003", rd); end
    n_checks++;
    if (lat !== 9) begin n_fail++; $display("FAIL ws3_latency: got %0d, expected 9", lat); end
    for (int t = 0; t < 6; t++) begin
      a = 19'($urandom) & 19'h7FFFC;
      e = {16'(int'(a >> 2) * 2), 16'(int'(a >> 2) * 2 + 1)};
      run3(a, lat, rd);
      n_checks++;
      if (rd !== e || lat !== exp_lat(1'b0, 4'h0, 3)) begin
        n_fail++; $display("FAIL ws3_random[%0d]: data=%h lat=%0d, expected %h/%0d", t, rd, lat, e, exp_lat(1'b0, 4'h0, 3));
      end
    end
  endtask

  task automatic test_reset_mid;
    bit          hit;
    int          dones;
    logic [31:0] d;
    hit = 1'b0;
    dones = 0;
    @(negedge clock);
    req = 1'b1; we = 1'b1; addr = 19'h02000; be = 4'hF; wdata = 32'hCAFEF00D;
    @(posedge clock);
    for (int c = 1; c <= 50; c++) begin
      @(negedge clock);
      req = 1'b0;
      if (!we1n && sa1[0]) begin hit = 1'b1; break; end
    end
    n_checks++;
    if (!hit) begin n_fail++; $display("FAIL reset_mid_reach_h1: got no H1 pulse, expected one"); end
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({ce1, we1n, oe1, ub1, lb1, busy1, done1} !== 7'b1111100) begin
      n_fail++; $display("FAIL reset_mid_release: got %b, expected 1111100", {ce1, we1n, oe1, ub1, lb1, busy1, done1});
    end
    repeat (3) begin
      @(negedge clock);
      if (done1) dones++;
    end
    reset_n = 1'b1;
    repeat (2) begin
      @(negedge clock);
      if (done1) dones++;
    end
    n_checks++;
    if (dones !== 0) begin n_fail++; $display("FAIL reset_mid_no_done: got %0d, expected 0", dones); end
    d = $urandom;
    run1(1'b1, 19'h03000, 4'hF, d, 1'b0);
    ref_write(19'h03000, 4'hF, d);
    n_checks++;
    if (o_lat !== 7) begin n_fail++; $display("FAIL reset_mid_write_after: lat=%0d, expected 7", o_lat); end
    run1(1'b0, 19'h03000, 4'h0, 32'h0, 1'b0);
    n_checks++;
    if (o_rdata !== ref_read(19'h03000) || o_lat !== 5) begin
      n_fail++; $display("FAIL reset_mid_read_after: data=%h lat=%0d, expected %h/5", o_rdata, o_lat, ref_read(19'h03000));
    end
  endtask

  initial begin
    for (int i = 0; i < 262144; i++) mem1[i] = 16'(i);
    test_reset;
    test_full_write;
    test_read;
    test_partial_write;
    test_zero_be;
    test_hold_req;
    test_random;
    test_wait_states;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
